// File: rtl/axi_rd_mem_model.sv
// AXI read-only memory model: queued AR requests, FIXED/INCR/WRAP bursts.
// Optional AXI_MEM_RANGE_CHECK_EN: out-of-range beats return 0 with SLVERR.
module axi_rd_mem_model #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int MEM_DEPTH   = 501760,
  parameter int LAT         = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] araddr,
  input  logic [7:0]    arlen,
  input  logic [1:0]    arburst,
  input  logic          arvalid,
  output logic          arready,
  output logic [DW-1:0] rdata,
  output logic [1:0]    rresp,
  output logic          rlast,
  output logic          rvalid,
  input  logic          rready
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam logic [CW-1:0] QMAX  = CW'(OUTSTANDING);
  localparam logic [PW-1:0] PLAST = PW'(OUTSTANDING - 1);
  localparam logic [3:0]    WMAX  = 4'(LAT > 1 ? LAT - 2 : 0);
  localparam logic [AW-1:0] DEPTH = AW'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
  state_t state;

  logic [AW-1:0] q_addr  [OUTSTANDING];
  logic [7:0]    q_len   [OUTSTANDING];
  logic [1:0]    q_burst [OUTSTANDING];

  logic [PW-1:0] wptr, rptr, rptr_inc, hd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop, load;
  logic [3:0]    wcnt;
  logic [7:0]    beat_k, nk;
  logic [AW-1:0] cur_addr;
  logic [7:0]    cur_len;
  logic [1:0]    cur_burst;
  logic [DW+1:0] ld_beat, nx_beat;

  // Memory word i holds i, so a read is just the resolved index.
  function automatic logic [DW+1:0] beat(
    input logic [AW-1:0] s,
    input logic [7:0]    len,
    input logic [1:0]    b,
    input logic [7:0]    k
  );
    logic [AW-1:0] m, a;
    logic          err, wrap_ok;
    m = AW'(len);
    wrap_ok = (b == 2'b10) &&
              (len == 8'd1 || len == 8'd3 ||
               len == 8'd7 || len == 8'd15);
    err = (b == 2'b11) || ((b == 2'b10) && !wrap_ok);
    unique case (1'b1)
      b == 2'b00: a = s;
      wrap_ok:    a = (s & ~m) | ((s + AW'(k)) & m);
      default:    a = s + AW'(k);
    endcase
`ifdef AXI_MEM_RANGE_CHECK_EN
    if (a >= DEPTH) return {2'b10, {DW{1'b0}}};
`else
    a = a % DEPTH;
`endif
    return {err ? 2'b10 : 2'b00, DW'(a)};
  endfunction

  assign rptr_inc = (rptr == PLAST) ? '0 : rptr + 1'b1;
  assign hd_ptr   = (state == BURST) ? rptr_inc : rptr;
  assign push     = arvalid && arready;
  assign pop      = rvalid && rready && rlast;
  assign nk       = beat_k + 8'd1;
  assign ld_beat  = beat(q_addr[hd_ptr], q_len[hd_ptr],
                         q_burst[hd_ptr], 8'd0);
  assign nx_beat  = beat(cur_addr, cur_len, cur_burst, nk);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
    load = 1'b0;
    unique case (state)
      IDLE:    load = (LAT == 1) && (count != '0);
      WAIT:    load = (wcnt == WMAX);
      BURST:   load = (LAT == 1) && pop && (count > CW'(1));
      default: load = 1'b0;
    endcase
  end

  // Entries stay queued until their last beat, so arready reflects bursts in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      arready <= 1'b1;
    end else begin
      if (push) begin
        q_addr[wptr]  <= araddr;
        q_len[wptr]   <= arlen;
        q_burst[wptr] <= arburst;
        wptr <= (wptr == PLAST) ? '0 : wptr + 1'b1;
      end
      if (pop) rptr <= rptr_inc;
      count   <= count_nxt;
      arready <= count_nxt < QMAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      beat_k    <= '0;
      cur_addr  <= '0;
      cur_len   <= '0;
      cur_burst <= '0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rresp     <= 2'b00;
      rdata     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (count != '0 && LAT > 1) begin
            state <= WAIT;
            wcnt  <= '0;
          end
        end
        WAIT: wcnt <= wcnt + 4'd1;
        BURST: begin
          if (rready) begin
            if (rlast) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
              wcnt   <= '0;
              state  <= (count > CW'(1)) ? WAIT : IDLE;
            end else begin
              beat_k          <= nk;
              {rresp, rdata}  <= nx_beat;
              rlast           <= (nk == cur_len);
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (load) begin
        state          <= BURST;
        beat_k         <= '0;
        cur_addr       <= q_addr[hd_ptr];
        cur_len        <= q_len[hd_ptr];
        cur_burst      <= q_burst[hd_ptr];
        {rresp, rdata} <= ld_beat;
        rvalid         <= 1'b1;
        rlast          <= (q_len[hd_ptr] == 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_mem_model.sv
// Directed bench for axi_rd_mem_model (default parameters).
module tb_axi_rd_mem_model;

  localparam int DEPTH = 501760;

  logic        clk;
  logic        rst_n;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] gd[$];
  logic [1:0]  gr[$];
  logic        gl[$];
  int          gc[$];

  axi_rd_mem_model #(
    .DW(32), .AW(32), .MEM_DEPTH(DEPTH), .LAT(2), .OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic send_ar(input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] b, output int acc,
                         output bit to);
    int w;
    to = 0;
    w = 0;
    @(negedge clk);
    araddr = a; arlen = l; arburst = b; arvalid = 1'b1;
    while (!arready && w < 100) begin
      @(negedge clk);
      w++;
    end
    to = !arready;
    acc = cyc + 1;
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic collect(input int n, input logic [3:0] pat,
                         input int maxc, output bit to);
    int i, cnt;
    gd.delete(); gr.delete(); gl.delete(); gc.delete();
    i = 0;
    cnt = 0;
    while (cnt < n && i < maxc) begin
      @(negedge clk);
      rready = pat[i % 4];
      i++;
      if (rvalid && rready) begin
        gd.push_back(rdata);
        gr.push_back(rresp);
        gl.push_back(rlast);
        gc.push_back(cyc);
        cnt++;
      end
    end
    to = (cnt < n);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (arready !== 1'b1) $display("FAIL reset_arready got=%b exp=1", arready); else pass_cnt++;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", rvalid); else pass_cnt++;
    total_cnt++; if (rlast !== 1'b0) $display("FAIL reset_rlast got=%b exp=0", rlast); else pass_cnt++;
    total_cnt++; if (rresp !== 2'b00) $display("FAIL reset_rresp got=%b exp=00", rresp); else pass_cnt++;
    total_cnt++; if (rdata !== 32'd0) $display("FAIL reset_rdata got=%0d exp=0", rdata); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_incr;
    int acc;
    bit to;
    send_ar(32'd100, 8'd3, 2'b01, acc, to);
    collect(4, 4'b1111, 50, to);
    total_cnt++; if (to) $display("FAIL incr_timeout got=%0d beats exp=4", gd.size()); else pass_cnt++;
    for (int k = 0; k < gd.size(); k++) begin
      total_cnt++; if (gd[k] !== 32'(100 + k)) $display("FAIL incr_data[%0d] got=%0d exp=%0d", k, gd[k], 100 + k); else pass_cnt++;
      total_cnt++; if (gl[k] !== (k == 3)) $display("FAIL incr_last[%0d] got=%b exp=%b", k, gl[k], k == 3); else pass_cnt++;
      total_cnt++; if (gr[k] !== 2'b00) $display("FAIL incr_resp[%0d] got=%b exp=00", k, gr[k]); else pass_cnt++;
    end
    if (gc.size() == 4) begin
      total_cnt++; if (gc[0] !== acc + 2) $display("FAIL incr_latency got=%0d exp=%0d", gc[0] - acc, 2); else pass_cnt++;
      total_cnt++; if (gc[3] !== gc[0] + 3) $display("FAIL incr_b2b got=%0d exp=%0d", gc[3] - gc[0], 3); else pass_cnt++;
    end
  endtask

  task automatic test_wrap_fixed;
    int acc;
    bit to;
    int ew[4] = '{6, 7, 4, 5};
    send_ar(32'd6, 8'd3, 2'b10, acc, to);
    collect(4, 4'b1111, 50, to);
    total_cnt++; if (to) $display("FAIL wrap_timeout got=%0d beats exp=4", gd.size()); else pass_cnt++;
    for (int k = 0; k < gd.size(); k++) begin
      total_cnt++; if (gd[k] !== 32'(ew[k]) || gr[k] !== 2'b00) $display("FAIL wrap_beat[%0d] got=%0d/%b exp=%0d/00", k, gd[k], gr[k], ew[k]); else pass_cnt++;
    end
    send_ar(32'd9, 8'd2, 2'b00, acc, to);
    collect(3, 4'b1111, 50, to);
    total_cnt++; if (to) $display("FAIL fixed_timeout got=%0d beats exp=3", gd.size()); else pass_cnt++;
    for (int k = 0; k < gd.size(); k++) begin
      total_cnt++; if (gd[k] !== 32'd9 || gl[k] !== (k == 2)) $display("FAIL fixed_beat[%0d] got=%0d last=%b exp=9 last=%b", k, gd[k], gl[k], k == 2); else pass_cnt++;
    end
  endtask

  task automatic test_err;
    int acc;
    bit to;
    send_ar(32'd10, 8'd2, 2'b10, acc, to);
    collect(3, 4'b1111, 50, to);
    total_cnt++; if (to) $display("FAIL wrap3_timeout got=%0d beats exp=3", gd.size()); else pass_cnt++;
    for (int k = 0; k < gd.size(); k++) begin
      total_cnt++; if (gd[k] !== 32'(10 + k) || gr[k] !== 2'b10) $display("FAIL wrap3_beat[%0d] got=%0d/%b exp=%0d/10", k, gd[k], gr[k], 10 + k); else pass_cnt++;
    end
    send_ar(32'd20, 8'd1, 2'b11, acc, to);
    collect(2, 4'b1111, 50, to);
    total_cnt++; if (to) $display("FAIL rsvd_timeout got=%0d beats exp=2", gd.size()); else pass_cnt++;
    for (int k = 0; k < gd.size(); k++) begin
      total_cnt++; if (gd[k] !== 32'(20 + k) || gr[k] !== 2'b10) $display("FAIL rsvd_beat[%0d] got=%0d/%b exp=%0d/10", k, gd[k], gr[k], 20 + k); else pass_cnt++;
    end
  endtask

  task automatic test_stall;
    int acc, i, cnt;
    bit to, ps, seen;
    logic [31:0] pd;
    logic pl;
    logic [3:0] pat;
    pat = 4'b1001;
    send_ar(32'd0, 8'd7, 2'b01, acc, to);
    ps = 0; i = 0; cnt = 0; pd = '0; pl = 1'b0;
    while (cnt < 8 && i < 200) begin
      @(negedge clk);
      if (ps) begin
        total_cnt++; if (rvalid !== 1'b1 || rdata !== pd || rlast !== pl) $display("FAIL stall_hold got=%b/%0d/%b exp=1/%0d/%b", rvalid, rdata, rlast, pd, pl); else pass_cnt++;
      end
      rready = pat[i % 4];
      i++;
      if (rvalid && rready) begin
        total_cnt++; if (rdata !== 32'(cnt) || rlast !== (cnt == 7)) $display("FAIL stall_beat[%0d] got=%0d/%b exp=%0d/%b", cnt, rdata, rlast, cnt, cnt == 7); else pass_cnt++;
        cnt++;
      end
      ps = rvalid && !rready;
      pd = rdata;
      pl = rlast;
    end
    total_cnt++; if (cnt !== 8) $display("FAIL stall_count got=%0d exp=8", cnt); else pass_cnt++;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid) seen = 1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL stall_extra_beat got=%b exp=0", seen); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int acc5, w;
    bit to_a, to_b;
    rready = 1'b0;
    acc5 = 0;
    to_a = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      araddr = 32'(200 + 100 * j); arlen = 8'd1; arburst = 2'b01;
      arvalid = 1'b1;
    end
    @(negedge clk);
    total_cnt++; if (arready !== 1'b0) $display("FAIL b2b_full got=%b exp=0", arready); else pass_cnt++;
    araddr = 32'd600;
    fork
      begin
        w = 0;
        while (!arready && w < 300) begin
          @(negedge clk);
          w++;
        end
        to_a = !arready;
        acc5 = cyc + 1;
        @(negedge clk);
        arvalid = 1'b0;
      end
      collect(10, 4'b1111, 300, to_b);
    join
    total_cnt++; if (to_a || to_b) $display("FAIL b2b_timeout got=%0d beats exp=10", gd.size()); else pass_cnt++;
    if (gc.size() >= 2) begin
      total_cnt++; if (acc5 !== gc[1] + 2) $display("FAIL b2b_fifth_accept got=%0d exp=%0d", acc5, gc[1] + 2); else pass_cnt++;
    end
    for (int k = 0; k < gd.size(); k++) begin
      total_cnt++; if (gd[k] !== 32'(200 + 100 * (k / 2) + k % 2) || gl[k] !== (k % 2 == 1)) $display("FAIL b2b_beat[%0d] got=%0d/%b exp=%0d/%b", k, gd[k], gl[k], 200 + 100 * (k / 2) + k % 2, k % 2 == 1); else pass_cnt++;
    end
  endtask

  task automatic test_range;
    int acc;
    bit to;
    logic [1:0] er1;
`ifdef AXI_MEM_RANGE_CHECK_EN
    er1 = 2'b10;
`else
    er1 = 2'b00;
`endif
    send_ar(32'(DEPTH - 1), 8'd1, 2'b01, acc, to);
    collect(2, 4'b1111, 50, to);
    total_cnt++; if (to) $display("FAIL range_timeout got=%0d beats exp=2", gd.size()); else pass_cnt++;
    if (gd.size() == 2) begin
      total_cnt++; if (gd[0] !== 32'(DEPTH - 1) || gr[0] !== 2'b00) $display("FAIL range_beat0 got=%0d/%b exp=%0d/00", gd[0], gr[0], DEPTH - 1); else pass_cnt++;
      total_cnt++; if (gd[1] !== 32'd0 || gr[1] !== er1) $display("FAIL range_beat1 got=%0d/%b exp=0/%b", gd[1], gr[1], er1); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    int acc, w;
    bit to, seen;
    send_ar(32'd30, 8'd7, 2'b01, acc, to);
    rready = 1'b1;
    w = 0;
    while (!(rvalid && rdata == 32'd32) && w < 50) begin
      @(negedge clk);
      w++;
    end
    total_cnt++; if (w >= 50) $display("FAIL rstmid_beat2 got=timeout exp=32"); else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++; if (rvalid !== 1'b0 || arready !== 1'b1) $display("FAIL rstmid_state got=%b/%b exp=0/1", rvalid, arready); else pass_cnt++;
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rvalid) seen = 1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL rstmid_stale_beat got=%b exp=0", seen); else pass_cnt++;
    send_ar(32'd50, 8'd0, 2'b01, acc, to);
    collect(1, 4'b1111, 50, to);
    total_cnt++; if (to) $display("FAIL rstmid_timeout got=%0d beats exp=1", gd.size()); else pass_cnt++;
    if (gd.size() == 1) begin
      total_cnt++; if (gd[0] !== 32'd50 || gl[0] !== 1'b1 || gr[0] !== 2'b00) $display("FAIL rstmid_single got=%0d/%b/%b exp=50/1/00", gd[0], gl[0], gr[0]); else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    araddr = '0; arlen = '0; arburst = 2'b01; arvalid = 1'b0;
    rready = 1'b0;
    test_reset();
    test_incr();
    test_wrap_fixed();
    test_err();
    test_stall();
    test_back_to_back();
    test_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
